// File: rtl/video_frame_crc_probe.sv
// Golden-signature probe for the PMOD video stream. It recovers the active window from the sync edges,
// then accumulates a CRC-16/CCITT, a lit-pixel count and a line count over one armed frame.
module video_frame_crc_probe #(
  parameter int H_START  = 160,
  parameter int H_ACTIVE = 1024,
  parameter int V_START  = 29,
  parameter int V_ACTIVE = 768,
  parameter int TO_BITS  = 22
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_vid_in,
  input  logic        i_arm,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_timeout,
  output logic [15:0] o_crc_out,
  output logic [19:0] o_lit_cnt,
  output logic [9:0]  o_line_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_ACCUM    = 2'd2;

  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO = 10'(V_START);
  localparam logic [9:0]  V_HI = 10'(V_START + V_ACTIVE);
  localparam logic [TO_BITS-1:0] WD_LAST = {TO_BITS{1'b1}};

  logic               r_hs_d;
  logic               r_vs_d;
  logic [10:0]        r_hpos;
  logic [9:0]         r_vline;
  logic [1:0]         r_state;
  logic [TO_BITS-1:0] r_wd;
  logic [15:0]        r_crc_acc;
  logic [19:0]        r_lit_acc;
  logic [9:0]         r_line_acc;
  logic [15:0]        r_crc_out;
  logic [19:0]        r_lit_cnt;
  logic [9:0]         r_line_cnt;
  logic               r_frame_done;
  logic               r_timeout;

  logic               w_hsync;
  logic               w_vsync;
  logic               w_hs_fall;
  logic               w_vs_rise;
  logic               w_vs_fall;
  logic               w_active;
  logic [7:0]         w_pix;
  logic [15:0]        w_crc_next;
  logic [19:0]        w_lit_next;
  logic [9:0]         w_line_next;
  logic [TO_BITS-1:0] w_wd_next;
  logic               w_wd_expire;

  // One byte folded MSB-first into CRC-16/CCITT (poly 0x1021, no reflection, no xorout).
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int b = 7; b >= 0; b--) begin
      if (c[15] ^ data[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign w_vsync   = i_vid_in[7];
  assign w_hsync   = i_vid_in[6];
  assign w_pix     = {2'b00, i_vid_in[5:0]};
  assign w_hs_fall = r_hs_d & ~w_hsync;
  assign w_vs_rise = ~r_vs_d & w_vsync;
  assign w_vs_fall = r_vs_d & ~w_vsync;
  assign w_active  = (r_hpos >= H_LO) && (r_hpos < H_HI) && (r_vline >= V_LO) && (r_vline < V_HI);

  assign w_crc_next  = w_active ? crc16_byte(r_crc_acc, w_pix) : r_crc_acc;
  assign w_lit_next  = r_lit_acc + 20'(w_active && (i_vid_in[5:0] != 6'd0));
  assign w_line_next = (w_hs_fall && (r_line_acc != 10'h3FF)) ? r_line_acc + 10'd1 : r_line_acc;
  assign w_wd_next   = r_wd + 1'b1;
  assign w_wd_expire = (w_wd_next == WD_LAST);

  // Timing recovery runs regardless of the measurement state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hs_d  <= 1'b0;
      r_vs_d  <= 1'b0;
      r_hpos  <= 11'd0;
      r_vline <= 10'd0;
    end else begin
      r_hs_d <= w_hsync;
      r_vs_d <= w_vsync;
      if (w_hs_fall)              r_hpos <= 11'd0;
      else if (r_hpos != 11'h7FF) r_hpos <= r_hpos + 11'd1;
      if (w_vs_fall)                             r_vline <= 10'd0;
      else if (w_hs_fall && r_vline != 10'h3FF)  r_vline <= r_vline + 10'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wd         <= '0;
      r_crc_acc    <= 16'hFFFF;
      r_lit_acc    <= 20'd0;
      r_line_acc   <= 10'd0;
      r_crc_out    <= 16'd0;
      r_lit_cnt    <= 20'd0;
      r_line_cnt   <= 10'd0;
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_arm) begin
            r_state   <= S_WAIT_SOF;
            r_timeout <= 1'b0;
            r_wd      <= '0;
          end
        end
        S_WAIT_SOF: begin
          if (w_vs_rise) begin
            r_state    <= S_ACCUM;
            r_crc_acc  <= 16'hFFFF;
            r_lit_acc  <= 20'd0;
            r_line_acc <= 10'd0;
            r_wd       <= '0;
          end else if (w_wd_expire) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wd <= w_wd_next;
          end
        end
        S_ACCUM: begin
          r_crc_acc  <= w_crc_next;
          r_lit_acc  <= w_lit_next;
          r_line_acc <= w_line_next;
          // The closing vs_rise cycle's own update is included in the latched results.
          if (w_vs_rise) begin
            r_crc_out    <= w_crc_next;
            r_lit_cnt    <= w_lit_next;
            r_line_cnt   <= w_line_next;
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end else if (w_wd_expire) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wd <= w_wd_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state == S_WAIT_SOF) || (r_state == S_ACCUM);
  assign o_frame_done = r_frame_done;
  assign o_timeout    = r_timeout;
  assign o_crc_out    = r_crc_out;
  assign o_lit_cnt    = r_lit_cnt;
  assign o_line_cnt   = r_line_cnt;

endmodule
